bomb_scheduler: RTL and testbench
=================================

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per game tick (>=2).
REQ-002 The block SHALL have parameter FUSE_TICKS, default 3, meaning ticks from placement to detonation (1..15).
REQ-003 The block SHALL have parameter CRACK_TICKS, default 1, meaning ticks a detonated slot stays in crack phase (1..15).
REQ-004 The block SHALL have port clk  input  1  system clock; this is the single clock, and all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port clear  input  1  synchronous clear of all slots (level 1 or new-game pulse).
REQ-007 The block SHALL have port place_req  input  1  one-cycle request to place a bomb.
REQ-008 The block SHALL have port place_x, place_y  input  6 each  block coordinates of requested bomb.
REQ-009 The block SHALL have port place_ack  output  1  one-cycle pulse, request accepted.
REQ-010 The block SHALL have port place_nack  output  1  one-cycle pulse, request rejected.
REQ-011 The block SHALL have port bomb_x, bomb_y  output  36 each  packed slot coordinates [1:36]; slot k occupies bits 6k-5..6k.
REQ-012 The block SHALL have port fuse_num  output  6  [1:6], bit k=1 while slot k is in FUSE.
REQ-013 The block SHALL have port crack_num  output  6  [1:6], bit k=1 while slot k is in CRACK; this port drives the crack renderer directly.

Function
REQ-014 The block SHALL generate an internal tick: the prescaler counts 0..TICK_DIV-1, and tick=1 for the one cycle the count equals TICK_DIV-1.
REQ-015 Each of the 6 slots SHALL run an FSM IDLE->FUSE->CRACK->IDLE with a 4-bit per-slot tick counter.
REQ-016 In FUSE, the slot SHALL decrement its counter on tick and enter CRACK on the tick where the counter is 1, loading CRACK_TICKS.
REQ-017 In CRACK, the slot SHALL decrement on tick and enter IDLE on the tick where the counter is 1.
REQ-018 On entering IDLE, the slot's bomb_x/bomb_y field SHALL be 0; fields SHALL hold the placed coordinates throughout FUSE and CRACK.
REQ-019 On place_req, the block SHALL select the lowest-numbered slot that is IDLE in the current cycle, load place_x/place_y, enter FUSE with counter=FUSE_TICKS, and pulse place_ack in the next cycle.
REQ-020 On place_req, the block SHALL pulse place_nack in the next cycle, with no state change, if no slot is IDLE or if any FUSE/CRACK slot already holds identical (x,y).
REQ-021 For each place_req, exactly one of place_ack/place_nack SHALL pulse, with latency 1 cycle.
REQ-022 A slot leaving CRACK in cycle N SHALL NOT be allocatable by a place_req in cycle N; it becomes allocatable in cycle N+1.
REQ-023 When place_req and tick coincide, the newly placed slot SHALL NOT consume that tick; its first decrement is on the next tick.
REQ-024 Outputs fuse_num, crack_num, bomb_x and bomb_y SHALL be registered and change 1 cycle after the causing event.
REQ-025 clear SHALL force all slots to IDLE, zero all outputs and reset the prescaler at the next edge; clear has priority over place_req (which is nacked) and over tick.

Reset
REQ-026 With rst_n=0, all slots SHALL be IDLE, the prescaler SHALL be 0, and bomb_x=bomb_y=0, fuse_num=crack_num=0 and place_ack=place_nack=0, asynchronously.
REQ-027 Reset asserted mid-FUSE or mid-CRACK SHALL discard that slot's state; after release, the first tick SHALL occur TICK_DIV cycles later.

Configuration
REQ-028 Macro BOMB_CHAIN_REACT_EN SHALL control chain detonation; when defined, a FUSE slot whose x equals any CRACK slot's x, or whose y equals any CRACK slot's y, SHALL enter CRACK at the next edge regardless of tick, loading CRACK_TICKS.
REQ-029 When BOMB_CHAIN_REACT_EN is not defined, slots SHALL leave FUSE only by counter expiry per REQ-016.

Verification
REQ-030 The bench SHALL cover: TICK_DIV=4, FUSE=3, CRACK=1, place (5,7) -> ack next cycle; fuse_num=100000, bomb_x[1:6]=5; crack_num=100000 after 3 ticks; all zero after 1 more tick.
REQ-031 The bench SHALL cover: 6 placements at distinct coordinates -> 6 acks filling slots 1..6 in order; a 7th request -> nack, outputs unchanged.
REQ-032 The bench SHALL cover: place (3,3) twice while the first is active -> second request nacked; slot 2 stays IDLE.
REQ-033 The bench SHALL cover: slot 1 leaving CRACK in the same cycle as place_req with slots 2..6 busy -> nack; repeating the request one cycle later -> ack into slot 1.
REQ-034 The bench SHALL cover: with BOMB_CHAIN_REACT_EN, bombs at (5,3) and (5,9) placed 1 tick apart -> slot 2 enters CRACK 1 cycle after slot 1 does; without the macro -> slot 2 enters CRACK 1 tick after slot 1.
REQ-035 The bench SHALL cover: rst_n pulsed low mid-FUSE -> all outputs 0 immediately; clear mid-CRACK -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bomb_scheduler.sv
// bomb_scheduler
// Six-slot bomb timer. Each slot runs IDLE -> FUSE -> CRACK -> IDLE, counting
// game ticks produced by an internal prescaler (one tick every TICK_DIV clks).
// Placement requests are answered one cycle later with place_ack or place_nack.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   clear               synchronous clear of all slots and the prescaler
//   place_req           one-cycle placement request
//   place_x, place_y    [5:0] block coordinates of the requested bomb
//   place_ack/_nack     one-cycle response pulses, one cycle after place_req
//   bomb_x, bomb_y      [1:36] packed slot coordinates, slot k at bits 6k-5..6k
//   fuse_num            [1:6] bit k set while slot k is in FUSE
//   crack_num           [1:6] bit k set while slot k is in CRACK
//
// Build option: define BOMB_CHAIN_REACT_EN to let a cracking bomb immediately
// detonate any fused bomb sharing its row or column.

module bomb_scheduler #(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned FUSE_TICKS  = 3,
  parameter int unsigned CRACK_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        place_req,
  input  logic [5:0]  place_x,
  input  logic [5:0]  place_y,
  output logic        place_ack,
  output logic        place_nack,
  output logic [1:36] bomb_x,
  output logic [1:36] bomb_y,
  output logic [1:6]  fuse_num,
  output logic [1:6]  crack_num
);

  localparam int unsigned     PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [3:0]      FUSE_LD  = 4'(FUSE_TICKS);
  localparam logic [3:0]      CRACK_LD = 4'(CRACK_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FUSE,
    S_CRACK
  } slot_state_t;

  logic [PW-1:0] r_pre;
  logic          w_tick;

  slot_state_t   r_state   [6];
  slot_state_t   w_state_nx[6];
  logic [3:0]    r_ctr     [6];
  logic [3:0]    w_ctr_nx  [6];
  logic [5:0]    r_x       [6];
  logic [5:0]    w_x_nx    [6];
  logic [5:0]    r_y       [6];
  logic [5:0]    w_y_nx    [6];

  logic          w_dup;
  logic          w_free_found;
  logic [2:0]    w_free_idx;
  logic          w_accept;

  logic [1:6]    w_fuse_nx;
  logic [1:6]    w_crack_nx;
  logic [1:6]    r_fuse;
  logic [1:6]    r_crack;
  logic          r_ack;
  logic          r_nack;

`ifdef BOMB_CHAIN_REACT_EN
  logic [5:0]    w_chain;

  // A fused slot is caught by any slot already cracking in its row or column.
  always_comb begin
    w_chain = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      for (int unsigned j = 0; j < 6; j++) begin
        if (r_state[i] == S_FUSE && r_state[j] == S_CRACK &&
            (r_x[j] == r_x[i] || r_y[j] == r_y[i])) begin
          w_chain[i] = 1'b1;
        end
      end
    end
  end
`endif

  assign w_tick = (r_pre == PRE_MAX);

  // Allocation looks only at the current registered state, so a slot that is
  // finishing CRACK this cycle is still busy and cannot be reused until the
  // following cycle.
  always_comb begin
    w_dup        = 1'b0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (r_state[i] != S_IDLE && r_x[i] == place_x && r_y[i] == place_y) begin
        w_dup = 1'b1;
      end
      if (!w_free_found && r_state[i] == S_IDLE) begin
        w_free_found = 1'b1;
        w_free_idx   = 3'(i);
      end
    end
    w_accept = place_req && !clear && w_free_found && !w_dup;
  end

  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      w_state_nx[i] = r_state[i];
      w_ctr_nx[i]   = r_ctr[i];
      w_x_nx[i]     = r_x[i];
      w_y_nx[i]     = r_y[i];

      unique case (r_state[i])
        S_IDLE: begin
          // A freshly placed slot loads the full fuse and ignores a
          // coincident tick.
          if (w_accept && w_free_idx == 3'(i)) begin
            w_state_nx[i] = S_FUSE;
            w_ctr_nx[i]   = FUSE_LD;
            w_x_nx[i]     = place_x;
            w_y_nx[i]     = place_y;
          end
        end
        S_FUSE: begin
`ifdef BOMB_CHAIN_REACT_EN
          if (w_chain[i]) begin
            w_state_nx[i] = S_CRACK;
            w_ctr_nx[i]   = CRACK_LD;
          end else
`endif
          if (w_tick) begin
            if (r_ctr[i] == 4'd1) begin
              w_state_nx[i] = S_CRACK;
              w_ctr_nx[i]   = CRACK_LD;
            end else begin
              w_ctr_nx[i] = r_ctr[i] - 4'd1;
            end
          end
        end
        S_CRACK: begin
          if (w_tick) begin
            if (r_ctr[i] == 4'd1) begin
              w_state_nx[i] = S_IDLE;
              w_ctr_nx[i]   = '0;
              w_x_nx[i]     = '0;
              w_y_nx[i]     = '0;
            end else begin
              w_ctr_nx[i] = r_ctr[i] - 4'd1;
            end
          end
        end
        default: begin
          w_state_nx[i] = S_IDLE;
          w_ctr_nx[i]   = '0;
          w_x_nx[i]     = '0;
          w_y_nx[i]     = '0;
        end
      endcase

      if (clear) begin
        w_state_nx[i] = S_IDLE;
        w_ctr_nx[i]   = '0;
        w_x_nx[i]     = '0;
        w_y_nx[i]     = '0;
      end
    end
  end

  always_comb begin
    w_fuse_nx  = '0;
    w_crack_nx = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      w_fuse_nx[i + 1]  = (w_state_nx[i] == S_FUSE);
      w_crack_nx[i + 1] = (w_state_nx[i] == S_CRACK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_fuse  <= '0;
      r_crack <= '0;
      r_ack   <= 1'b0;
      r_nack  <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
        r_state[i] <= S_IDLE;
        r_ctr[i]   <= '0;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
      end
    end else begin
      if (clear || w_tick) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      r_fuse  <= w_fuse_nx;
      r_crack <= w_crack_nx;
      r_ack   <= w_accept;
      r_nack  <= place_req && !w_accept;
      for (int unsigned i = 0; i < 6; i++) begin
        r_state[i] <= w_state_nx[i];
        r_ctr[i]   <= w_ctr_nx[i];
        r_x[i]     <= w_x_nx[i];
        r_y[i]     <= w_y_nx[i];
      end
    end
  end

  always_comb begin
    bomb_x = '0;
    bomb_y = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      bomb_x[6*i + 1 +: 6] = r_x[i];
      bomb_y[6*i + 1 +: 6] = r_y[i];
    end
  end

  assign fuse_num   = r_fuse;
  assign crack_num  = r_crack;
  assign place_ack  = r_ack;
  assign place_nack = r_nack;

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler
// Directed bench for bomb_scheduler with TICK_DIV=4, FUSE_TICKS=3,
// CRACK_TICKS=1. Place responses are checked through an expectation queue;
// slot outputs are checked against hand-derived constants. The chain-reaction
// expectations follow BOMB_CHAIN_REACT_EN when the bench is built with it.

module tb_bomb_scheduler;

  localparam int unsigned TD = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clear     = 1'b0;
  logic        place_req = 1'b0;
  logic [5:0]  place_x   = '0;
  logic [5:0]  place_y   = '0;
  logic        place_ack;
  logic        place_nack;
  logic [1:36] bomb_x;
  logic [1:36] bomb_y;
  logic [1:6]  fuse_num;
  logic [1:6]  crack_num;

  bomb_scheduler #(
    .TICK_DIV   (TD),
    .FUSE_TICKS (3),
    .CRACK_TICKS(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .place_req (place_req),
    .place_x   (place_x),
    .place_y   (place_y),
    .place_ack (place_ack),
    .place_nack(place_nack),
    .bomb_x    (bomb_x),
    .bomb_y    (bomb_y),
    .fuse_num  (fuse_num),
    .crack_num (crack_num)
  );

  always #5 clk = ~clk;

  int          n_cmp    = 0;
  int          n_fail   = 0;
  int unsigned tb_cnt   = 0;   // bench's own prescaler phase
  int unsigned tb_ticks = 0;   // tick edges crossed so far
  bit          sb_q[$];        // 1 = ack expected, 0 = nack expected

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples live 1 time unit after the edge.
  task automatic step();
    int unsigned nx;
    bit          tk;
    bit          e;
    tk = (tb_cnt == TD - 1) && !clear;
    if (clear) nx = 0;
    else       nx = tk ? 0 : tb_cnt + 1;
    @(posedge clk);
    #1;
    tb_cnt = nx;
    if (tk) tb_ticks++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ack", place_ack, e);
      chk("nack", place_nack, !e);
    end else begin
      chk("ack_quiet", place_ack, 0);
      chk("nack_quiet", place_nack, 0);
    end
  endtask

  task automatic place(input logic [5:0] x, input logic [5:0] y, input bit exp_ack);
    place_x   = x;
    place_y   = y;
    place_req = 1'b1;
    sb_q.push_back(exp_ack);
    step();
    place_req = 1'b0;
  endtask

  task automatic tick_edges(input int unsigned n);
    int unsigned target;
    target = tb_ticks + n;
    while (tb_ticks < target) step();
  endtask

  task automatic align0();
    while (tb_cnt != 0) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fuse"},  fuse_num,  0);
    chk({tag, "_crack"}, crack_num, 0);
    chk({tag, "_bx"},    bomb_x,    0);
    chk({tag, "_by"},    bomb_y,    0);
  endtask

  initial begin
    logic [1:36] ex;
    logic [1:36] ey;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    chk("rst_ack", place_ack, 0);
    chk("rst_nack", place_nack, 0);
    rst_n  = 1'b1;
    tb_cnt = 0;

    // Single bomb lifecycle at (5,7)
    place(6'd5, 6'd7, 1'b1);
    chk("t1_fuse", fuse_num, 6'b100000);
    chk("t1_crack", crack_num, 6'b000000);
    chk("t1_bx", bomb_x[1:6], 6'd5);
    chk("t1_by", bomb_y[1:6], 6'd7);
    tick_edges(2);
    chk("t1_fuse2", fuse_num, 6'b100000);
    tick_edges(1);
    chk("t1_crack3", crack_num, 6'b100000);
    chk("t1_fuse3", fuse_num, 6'b000000);
    chk("t1_bx3", bomb_x[1:6], 6'd5);
    tick_edges(1);
    chk_all_zero("t1_end");

    // Fill all six slots in order, seventh rejected
    ex = '0;
    ey = '0;
    for (int k = 1; k <= 6; k++) begin
      place(6'(10 + k), 6'(20 + k), 1'b1);
      ex[6*k - 5 +: 6] = 6'(10 + k);
      ey[6*k - 5 +: 6] = 6'(20 + k);
    end
    chk("t2_fuse", fuse_num, 6'b111111);
    chk("t2_bx", bomb_x, ex);
    chk("t2_by", bomb_y, ey);
    place(6'd40, 6'd40, 1'b0);
    chk("t2_fuse7", fuse_num, 6'b111111);
    chk("t2_crack7", crack_num, 6'b000000);
    chk("t2_bx7", bomb_x, ex);
    chk("t2_by7", bomb_y, ey);
    tick_edges(6);
    chk_all_zero("t2_end");

    // Duplicate coordinates rejected
    place(6'd3, 6'd3, 1'b1);
    place(6'd3, 6'd3, 1'b0);
    chk("t3_fuse", fuse_num, 6'b100000);
    chk("t3_bx1", bomb_x[1:6], 6'd3);
    chk("t3_bx2", bomb_x[7:12], 6'd0);
    chk("t3_by2", bomb_y[7:12], 6'd0);
    tick_edges(5);
    chk_all_zero("t3_end");

    // Slot leaving CRACK is not reusable in the same cycle
    align0();
    place(6'd1, 6'd1, 1'b1);
    tick_edges(1);
    for (int k = 2; k <= 6; k++) place(6'(k), 6'(k), 1'b1);
    tick_edges(1);
    chk("t4_crack", crack_num, 6'b100000);
    chk("t4_fuse", fuse_num, 6'b011111);
    while (tb_cnt != TD - 1) step();
    place(6'd50, 6'd50, 1'b0);
    chk("t4_crack_n", crack_num, 6'b011100);
    chk("t4_fuse_n", fuse_num, 6'b000011);
    chk("t4_bx_n", bomb_x[1:6], 6'd0);
    place(6'd50, 6'd50, 1'b1);
    chk("t4_fuse_a", fuse_num, 6'b100011);
    chk("t4_bx_a", bomb_x[1:6], 6'd50);
    chk("t4_by_a", bomb_y[1:6], 6'd50);
    tick_edges(6);
    chk_all_zero("t4_end");

    // Same column, one tick apart
    align0();
    place(6'd5, 6'd3, 1'b1);
    tick_edges(1);
    place(6'd5, 6'd9, 1'b1);
    tick_edges(2);
    chk("t5_crack_a", crack_num, 6'b100000);
    chk("t5_fuse_a", fuse_num, 6'b010000);
    step();
`ifdef BOMB_CHAIN_REACT_EN
    chk("t5_crack_b", crack_num, 6'b110000);
    chk("t5_fuse_b", fuse_num, 6'b000000);
    chk("t5_by2_b", bomb_y[7:12], 6'd9);
    tick_edges(1);
    chk("t5_crack_c", crack_num, 6'b000000);
`else
    chk("t5_crack_b", crack_num, 6'b100000);
    chk("t5_fuse_b", fuse_num, 6'b010000);
    tick_edges(1);
    chk("t5_crack_c", crack_num, 6'b010000);
    chk("t5_bx2_c", bomb_x[7:12], 6'd5);
    chk("t5_by2_c", bomb_y[7:12], 6'd9);
`endif
    tick_edges(2);
    chk_all_zero("t5_end");

    // Asynchronous reset mid-FUSE
    place(6'd7, 6'd7, 1'b1);
    step();
    rst_n = 1'b0;
    #2;
    chk_all_zero("t6_rst");
    chk("t6_rst_ack", place_ack, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tb_cnt = 0;
    // First tick lands TICK_DIV cycles after release
    place(6'd8, 6'd8, 1'b1);
    repeat (10) step();
    chk("t6_fuse_pre", fuse_num, 6'b100000);
    chk("t6_crack_pre", crack_num, 6'b000000);
    step();
    chk("t6_crack", crack_num, 6'b100000);

    // Clear mid-CRACK beats a coincident place_req
    place_x   = 6'd50;
    place_y   = 6'd50;
    place_req = 1'b1;
    clear     = 1'b1;
    sb_q.push_back(1'b0);
    step();
    clear     = 1'b0;
    place_req = 1'b0;
    chk_all_zero("t7_clr");
    // Prescaler restarts from zero after clear
    place(6'd9, 6'd9, 1'b1);
    repeat (10) step();
    chk("t7_fuse_pre", fuse_num, 6'b100000);
    step();
    chk("t7_crack", crack_num, 6'b100000);
    chk("t7_bx", bomb_x[1:6], 6'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
